// File: rtl/modul_t1us_pps.sv
// 1 us tick generator with optional GPS 1PPS phase alignment, PPS period
// qualification (lock/error/seen status) and us-within-second count.
module modul_t1us_pps #(
    parameter int DIV        = 100,
    parameter int HIGH_CYC   = 50,
    parameter int US_PER_SEC = 1000000,
    parameter int PPS_TOL    = 2,
    parameter int LOCK_CNT   = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pps_in,
    input  logic        pps_en,
    output logic        t1us,
    output logic [19:0] us_cnt,
    output logic        pps_lock,
    output logic        pps_err,
    output logic        pps_seen
);

    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int TMO_US = US_PER_SEC + US_PER_SEC / 2;

    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0]  HIGH_V   = DIV_W'(HIGH_CYC);
    localparam logic [19:0]       US_LAST  = 20'(US_PER_SEC - 1);
    localparam logic [20:0]       PER_MAX  = '1;
    localparam logic [20:0]       TMO_M1   = 21'(TMO_US - 1);
    localparam logic [21:0]       PER_LO   = 22'(US_PER_SEC - PPS_TOL);
    localparam logic [21:0]       PER_HI   = 22'(US_PER_SEC + PPS_TOL);
    localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_CNT);

    typedef enum logic [1:0] {
        ST_FREE = 2'd0,
        ST_ACQ  = 2'd1,
        ST_LOCK = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               pps_s1_q, pps_s2_q, pps_dly_q;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [19:0]        us_cnt_q, us_cnt_d;
    logic [20:0]        per_cnt_q, per_cnt_d;
    logic [GOOD_W-1:0]  good_cnt_q, good_cnt_d;
    logic               t1us_q, t1us_d;
    logic               lock_q, lock_d;
    logic               err_q, err_d;
    logic               seen_q, seen_d;

    logic               pps_rise;
    logic               us_tick;
    logic               tmo_hit;
    logic               period_ok;
    logic [21:0]        per_eff;
    logic [GOOD_W-1:0]  good_inc;

    always_comb begin
        pps_rise = pps_s2_q & ~pps_dly_q;
        us_tick  = (div_cnt_q == DIV_LAST);
        // Period as it would read after this cycle's tick, so an on-time edge
        // that coincides with the tick measures exactly US_PER_SEC.
        per_eff   = {1'b0, per_cnt_q} + 22'(us_tick);
        period_ok = (per_eff >= PER_LO) && (per_eff <= PER_HI);
        tmo_hit   = us_tick && (per_cnt_q == TMO_M1);
        good_inc  = (good_cnt_q == GOOD_MAX) ? good_cnt_q : good_cnt_q + 1'b1;

        div_cnt_d  = us_tick ? '0 : div_cnt_q + 1'b1;
        us_cnt_d   = us_cnt_q;
        if (us_tick) begin
            us_cnt_d = (us_cnt_q == US_LAST) ? 20'd0 : us_cnt_q + 20'd1;
        end
        per_cnt_d  = (us_tick && per_cnt_q != PER_MAX) ? per_cnt_q + 21'd1 : per_cnt_q;
        t1us_d     = (div_cnt_q < HIGH_V);
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        err_d      = 1'b0;
        seen_d     = seen_q;

        if (!pps_en) begin
            state_d    = ST_FREE;
            good_cnt_d = '0;
        end else if (pps_rise) begin
            div_cnt_d = '0;
            us_cnt_d  = 20'd0;
            per_cnt_d = 21'd0;
            seen_d    = 1'b1;
            if (state_q == ST_FREE) begin
                // No reference period yet: treat as bad but do not flag it.
                state_d    = ST_ACQ;
                good_cnt_d = '0;
            end else if (period_ok) begin
                good_cnt_d = good_inc;
                state_d    = (good_inc == GOOD_MAX) ? ST_LOCK : ST_ACQ;
            end else begin
                good_cnt_d = '0;
                err_d      = 1'b1;
                state_d    = ST_ACQ;
            end
        end else if (tmo_hit && (state_q == ST_ACQ || state_q == ST_LOCK)) begin
            err_d      = 1'b1;
            good_cnt_d = '0;
            if (state_q == ST_LOCK) begin
                state_d = ST_HOLD;
            end
        end

        lock_d = (state_d == ST_LOCK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pps_s1_q   <= 1'b0;
            pps_s2_q   <= 1'b0;
            pps_dly_q  <= 1'b0;
            state_q    <= ST_FREE;
            div_cnt_q  <= '0;
            us_cnt_q   <= 20'd0;
            per_cnt_q  <= 21'd0;
            good_cnt_q <= '0;
            t1us_q     <= 1'b0;
            lock_q     <= 1'b0;
            err_q      <= 1'b0;
            seen_q     <= 1'b0;
        end else begin
            pps_s1_q   <= pps_in;
            pps_s2_q   <= pps_s1_q;
            pps_dly_q  <= pps_s2_q;
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            us_cnt_q   <= us_cnt_d;
            per_cnt_q  <= per_cnt_d;
            good_cnt_q <= good_cnt_d;
            t1us_q     <= t1us_d;
            lock_q     <= lock_d;
            err_q      <= err_d;
            seen_q     <= seen_d;
        end
    end

    assign t1us     = t1us_q;
    assign us_cnt   = us_cnt_q;
    assign pps_lock = lock_q;
    assign pps_err  = err_q;
    assign pps_seen = seen_q;

endmodule
